// File: rtl/stage_pkg.sv
// Shared types and constants for the game flow controller and its address mux.
package stage_pkg;

    localparam int NUM_STAGES = 6;
    localparam int ADDR_W     = 25;
    localparam int CNT_W      = 4;

    typedef enum logic [3:0] {
        MENU  = 4'd0,
        LVL1  = 4'd1,
        BOSS  = 4'd2,
        DEATH = 4'd3,
        FINAL = 4'd4,
        EXIT  = 4'd5
    } stage_t;

    // One-hot reset vector for a single stage; out-of-range codes give all zeros.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_t s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (s == stage_t'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/stage_addr_mux.sv
// Selects the frame-buffer write address of the active stage; any other
// stage code yields address zero. Purely combinational.
module stage_addr_mux
    import stage_pkg::*;
(
    input  logic [3:0]        stage,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [ADDR_W-1:0] addr4,
    input  logic [ADDR_W-1:0] addr5,
    output logic [ADDR_W-1:0] addr_out
);

    logic [ADDR_W-1:0] addr_arr [NUM_STAGES];
    logic [ADDR_W-1:0] gated    [NUM_STAGES];

    assign addr_arr[0] = addr0;
    assign addr_arr[1] = addr1;
    assign addr_arr[2] = addr2;
    assign addr_arr[3] = addr3;
    assign addr_arr[4] = addr4;
    assign addr_arr[5] = addr5;

    // Each lane passes its address only when its stage is the current one.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_gate
            assign gated[gi] = (stage == 4'(gi)) ? addr_arr[gi] : '0;
        end
    endgenerate

    // At most one lane is non-zero, so an OR merge is a clean select.
    always_comb begin
        addr_out = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            addr_out = addr_out | gated[i];
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Game flow controller: owns the current stage, issues per-stage reset pulses
// after each stage entry, tracks save checkpoint and death count, and merges
// the per-stage frame-buffer addresses.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int RST_FRAMES = 2
) (
    input  logic                  frame_clk,
    input  logic                  Reset_h,
    input  logic                  confirmed,
    input  logic [3:0]            selected_stage,
    input  logic                  saved1,
    input  logic                  saved2,
    input  logic                  reach_final,
    input  logic                  death1,
    input  logic                  death2,
    input  logic                  victory,
    input  logic                  R,
    input  logic                  finish_game,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [ADDR_W-1:0]     addr2,
    input  logic [ADDR_W-1:0]     addr3,
    input  logic [ADDR_W-1:0]     addr4,
    input  logic [ADDR_W-1:0]     addr5,
    output logic [3:0]            stage,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [3:0]            checkpoint,
    output logic [7:0]            death_count,
    output logic [ADDR_W-1:0]     Address
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(RST_FRAMES);

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       checkpoint_q, checkpoint_d;
    logic [7:0]       death_count_q, death_count_d;
    logic             r_prev_q, r_prev_d;
    logic             all_rst_q, all_rst_d;   // power-on: reset every stage, not just one
    logic             enter;
    logic             r_rise;

    assign r_rise = R & ~r_prev_q;

    // State register; a held R during reset is captured so it cannot resurrect.
    always_ff @(posedge frame_clk) begin
        if (Reset_h) begin
            stage_q       <= MENU;
            cnt_q         <= SETTLE_LOAD;
            checkpoint_q  <= 4'd1;
            death_count_q <= 8'd0;
            r_prev_q      <= R;
            all_rst_q     <= 1'b1;
        end else begin
            stage_q       <= stage_d;
            cnt_q         <= cnt_d;
            checkpoint_q  <= checkpoint_d;
            death_count_q <= death_count_d;
            r_prev_q      <= r_prev_d;
            all_rst_q     <= all_rst_d;
        end
    end

    // Next-state logic: stage events are honoured only once the settle counter has drained.
    always_comb begin
        stage_d       = stage_q;
        cnt_d         = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        checkpoint_d  = checkpoint_q;
        death_count_d = death_count_q;
        r_prev_d      = R;
        all_rst_d     = all_rst_q;
        enter         = 1'b0;

        if (cnt_q == '0) begin
            unique case (stage_q)
                MENU: begin
                    if (confirmed) begin
                        case (selected_stage)
                            4'd1: begin
                                stage_d      = LVL1;
                                checkpoint_d = 4'd1;
                                enter        = 1'b1;
                            end
                            4'd2: begin
                                stage_d = (checkpoint_q == 4'd2) ? BOSS : LVL1;
                                enter   = 1'b1;
                            end
                            4'd3: begin
                                stage_d = EXIT;
                                enter   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                LVL1: begin
                    if (death1) begin
                        stage_d = DEATH;
                        enter   = 1'b1;
                        if (death_count_q != 8'hFF) begin
                            death_count_d = death_count_q + 8'd1;
                        end
                    end else if (reach_final) begin
                        stage_d = BOSS;
                        enter   = 1'b1;
                    end else if (saved1) begin
                        checkpoint_d = 4'd1;
                    end
                end
                BOSS: begin
                    if (death2) begin
                        stage_d = DEATH;
                        enter   = 1'b1;
                        if (death_count_q != 8'hFF) begin
                            death_count_d = death_count_q + 8'd1;
                        end
                    end else begin
                        // A save in the victory frame still counts.
                        if (saved2) begin
                            checkpoint_d = 4'd2;
                        end
                        if (victory) begin
                            stage_d = FINAL;
                            enter   = 1'b1;
                        end
                    end
                end
                DEATH: begin
                    if (r_rise) begin
                        stage_d = (checkpoint_q == 4'd2) ? BOSS : LVL1;
                        enter   = 1'b1;
                    end
                end
                FINAL: begin
                    if (finish_game) begin
                        stage_d = MENU;
                        enter   = 1'b1;
                    end
                end
                EXIT: ;
                default: ;
            endcase
        end

        if (enter) begin
            cnt_d     = SETTLE_LOAD;
            all_rst_d = 1'b0;
        end
    end

    // Outputs: reset pulse for the stage being settled, plus registered status.
    always_comb begin
        stage_rst = '0;
        if (cnt_q != '0) begin
            stage_rst = all_rst_q ? '1 : stage_onehot(stage_q);
        end
        stage       = stage_q;
        checkpoint  = checkpoint_q;
        death_count = death_count_q;
    end

    stage_addr_mux u_addr_mux (
        .stage    (stage_q),
        .addr0    (addr0),
        .addr1    (addr1),
        .addr2    (addr2),
        .addr3    (addr3),
        .addr4    (addr4),
        .addr5    (addr5),
        .addr_out (Address)
    );

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed game-flow scenarios plus random frames,
// every frame compared against a frame-age based reference model.
module tb_stage_sequencer;

    localparam int RF = 2;

    logic        frame_clk = 1'b0;
    logic        Reset_h;
    logic        confirmed;
    logic [3:0]  selected_stage;
    logic        saved1, saved2, reach_final, death1, death2, victory, R, finish_game;
    logic [24:0] addr0, addr1, addr2, addr3, addr4, addr5;
    logic [3:0]  stage;
    logic [5:0]  stage_rst;
    logic [3:0]  checkpoint;
    logic [7:0]  death_count;
    logic [24:0] Address;

    int tests_run = 0;
    int tests_failed = 0;
    int frame_no = 0;

    // Reference model: stage, frames elapsed since entering it, and game bookkeeping.
    int m_stage, m_age, m_ckpt, m_deaths;
    bit m_all, m_rprev;

    always #5 frame_clk = ~frame_clk;

    stage_sequencer #(.RST_FRAMES(RF)) dut (
        .frame_clk      (frame_clk),
        .Reset_h        (Reset_h),
        .confirmed      (confirmed),
        .selected_stage (selected_stage),
        .saved1         (saved1),
        .saved2         (saved2),
        .reach_final    (reach_final),
        .death1         (death1),
        .death2         (death2),
        .victory        (victory),
        .R              (R),
        .finish_game    (finish_game),
        .addr0          (addr0),
        .addr1          (addr1),
        .addr2          (addr2),
        .addr3          (addr3),
        .addr4          (addr4),
        .addr5          (addr5),
        .stage          (stage),
        .stage_rst      (stage_rst),
        .checkpoint     (checkpoint),
        .death_count    (death_count),
        .Address        (Address)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (frame %0d)", tag, obs, exp, frame_no);
        end
    endtask

    task automatic clear_events();
        confirmed = 0; selected_stage = 0; saved1 = 0; saved2 = 0; reach_final = 0;
        death1 = 0; death2 = 0; victory = 0; finish_game = 0;
    endtask

    task automatic rand_addrs();
        addr0 = 25'($urandom); addr1 = 25'($urandom); addr2 = 25'($urandom);
        addr3 = 25'($urandom); addr4 = 25'($urandom); addr5 = 25'($urandom);
    endtask

    // Apply the game rules to the inputs seen at this frame edge.
    task automatic model_edge();
        int  nxt;
        bit  rise;
        if (Reset_h) begin
            m_stage = 0; m_ckpt = 1; m_deaths = 0; m_age = 0; m_all = 1; m_rprev = R;
            return;
        end
        nxt  = -1;
        rise = R && !m_rprev;
        m_rprev = R;
        if (m_age >= RF) begin
            case (m_stage)
                0: if (confirmed) begin
                       if (selected_stage == 1) begin nxt = 1; m_ckpt = 1; end
                       else if (selected_stage == 2) nxt = m_ckpt;
                       else if (selected_stage == 3) nxt = 5;
                   end
                1: if (death1) begin nxt = 3; m_deaths = (m_deaths < 255) ? m_deaths + 1 : 255; end
                   else if (reach_final) nxt = 2;
                2: if (death2) begin nxt = 3; m_deaths = (m_deaths < 255) ? m_deaths + 1 : 255; end
                   else begin
                       if (saved2) m_ckpt = 2;
                       if (victory) nxt = 4;
                   end
                3: if (rise) nxt = m_ckpt;
                4: if (finish_game) nxt = 0;
                default: ;
            endcase
        end
        if (nxt >= 0) begin
            m_stage = nxt; m_age = 0; m_all = 0;
        end else if (m_age < RF) begin
            m_age++;
        end
    endtask

    task automatic check_outputs();
        logic [5:0]  exp_rst;
        logic [24:0] exp_addr;
        logic [24:0] a [6];
        a[0] = addr0; a[1] = addr1; a[2] = addr2; a[3] = addr3; a[4] = addr4; a[5] = addr5;
        exp_rst  = (m_age < RF) ? (m_all ? 6'h3F : 6'(1 << m_stage)) : 6'h00;
        exp_addr = (m_stage <= 5) ? a[m_stage] : 25'd0;
        check_eq("stage",       32'(stage),       32'(m_stage));
        check_eq("stage_rst",   32'(stage_rst),   32'(exp_rst));
        check_eq("checkpoint",  32'(checkpoint),  32'(m_ckpt));
        check_eq("death_count", 32'(death_count), 32'(m_deaths));
        check_eq("Address",     32'(Address),     32'(exp_addr));
    endtask

    // One frame: edge, model update, compare just after the edge.
    task automatic frame();
        @(posedge frame_clk);
        model_edge();
        #1;
        frame_no++;
        check_outputs();
        $display("[TB] frame %0d rst=%0b stage=%0d stage_rst=%b ckpt=%0d deaths=%0d",
                 frame_no, Reset_h, stage, stage_rst, checkpoint, death_count);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic do_reset();
        clear_events();
        Reset_h = 1;
        frames(2);
        Reset_h = 0;
    endtask

    initial begin
        clear_events();
        R = 0;
        Reset_h = 1;
        rand_addrs();
        #2;
        frames(2);
        check_eq("reset_stage", 32'(stage), 32'd0);
        check_eq("reset_rst", 32'(stage_rst), 32'h3F);
        check_eq("reset_ckpt", 32'(checkpoint), 32'd1);
        Reset_h = 0;
        frames(RF);

        // Start game; death during settle frames must be ignored.
        confirmed = 1; selected_stage = 4'd1;
        frame();
        check_eq("start_stage", 32'(stage), 32'd1);
        check_eq("start_rst", 32'(stage_rst), 32'h02);
        clear_events();
        death1 = 1;
        frames(RF);
        check_eq("masked_death", 32'(stage), 32'd1);
        // Address routing in stage 1.
        addr1 = 25'h1ABCDE;
        #1;
        check_eq("addr_stage1", 32'(Address), 32'h1ABCDE);
        // Death beats teleport.
        reach_final = 1;
        frame();
        check_eq("death_prio", 32'(stage), 32'd3);
        check_eq("death_cnt1", 32'(death_count), 32'd1);
        clear_events();

        // Resurrect into level 1, go to boss, save, die, resurrect into boss.
        frames(RF);
        R = 1; frame(); R = 0;
        frames(RF);
        reach_final = 1; frame(); clear_events();
        frames(RF);
        saved2 = 1; frame(); clear_events();
        check_eq("save2_ckpt", 32'(checkpoint), 32'd2);
        death2 = 1; frame(); clear_events();
        check_eq("boss_death", 32'(stage), 32'd3);
        frames(RF);
        R = 1; frame();
        check_eq("resurrect_boss", 32'(stage), 32'd2);
        // R held across reset: no resurrect afterwards.
        do_reset();
        frames(RF + 2);
        check_eq("held_r_stage", 32'(stage), 32'd0);
        R = 0;

        // Load after reset goes to level 1.
        confirmed = 1; selected_stage = 4'd2; frame(); clear_events();
        check_eq("load_default", 32'(stage), 32'd1);
        frames(RF);
        reach_final = 1; frame(); clear_events();
        frames(RF);
        saved2 = 1; victory = 1; frame(); clear_events();
        check_eq("victory", 32'(stage), 32'd4);
        frames(RF);
        finish_game = 1; frame(); clear_events();
        check_eq("finish", 32'(stage), 32'd0);
        frames(RF);
        confirmed = 1; selected_stage = 4'd3; frame(); clear_events();
        check_eq("exit", 32'(stage), 32'd5);
        for (int i = 0; i < 20; i++) begin
            confirmed = 1'($urandom); selected_stage = 4'($urandom); death1 = 1'($urandom);
            reach_final = 1'($urandom); victory = 1'($urandom); finish_game = 1'($urandom);
            R = 1'($urandom); rand_addrs();
            frame();
        end
        check_eq("exit_terminal", 32'(stage), 32'd5);

        // Death saturation: drive the shortest die-resurrect loop.
        do_reset();
        R = 0;
        for (int i = 0; i < 2400; i++) begin
            clear_events();
            if (m_stage == 0) begin confirmed = 1; selected_stage = 4'd1; end
            if (m_stage == 1) death1 = 1;
            if (m_stage == 3) R = ~R;
            frame();
        end
        check_eq("death_sat", 32'(death_count), 32'd255);

        // Randomized frames with sparse events and rare resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            Reset_h        = ($urandom_range(0, 199) == 0);
            confirmed      = ($urandom_range(0, 3) == 0);
            selected_stage = 4'($urandom_range(0, 4));
            saved1         = ($urandom_range(0, 3) == 0);
            saved2         = ($urandom_range(0, 3) == 0);
            reach_final    = ($urandom_range(0, 5) == 0);
            death1         = ($urandom_range(0, 7) == 0);
            death2         = ($urandom_range(0, 7) == 0);
            victory        = ($urandom_range(0, 7) == 0);
            finish_game    = ($urandom_range(0, 3) == 0);
            R              = ($urandom_range(0, 2) == 0) ? ~R : R;
            rand_addrs();
            frame();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Top-level game flow controller that owns the `stage` register consumed by every stage block (menu, level 1, boss, death screen, final grade, exit screen). It samples each stage's completion/event outputs, sequences transitions, issues per-stage reset pulses, tracks the save checkpoint and death count, and merges the per-stage frame-buffer `Address` outputs into the single write address for the SDRAM writer.

## Interface
- `RST_FRAMES`, 2: frames a per-stage reset is held after entering a stage; stage events ignored meanwhile (1–15).
- `frame_clk` in 1: frame clock; all state changes on its rising edge.
- `Reset_h` in 1: synchronous, active-high reset.
- `confirmed` in 1: menu selection accepted (from menu stage).
- `selected_stage` in 4: menu choice, 1=start, 2=load, 3=exit.
- `saved1`, `saved2` in 1: save point hit in level 1 / boss stage.
- `reach_final` in 1: teleport reached in level 1.
- `death1`, `death2` in 1: kid killed in level 1 / boss stage.
- `victory` in 1: boss dead.
- `R` in 1: resurrect key (level-sensitive; block edge-detects).
- `finish_game` in 1: grade confirmed on final screen.
- `addr0`..`addr5` in 25 each: per-stage `Address` (each already 0 when its stage is inactive).
- `stage` out 4: current stage, 0 menu, 1 level 1, 2 boss, 3 death, 4 final, 5 exit.
- `stage_rst` out 6: one-hot-per-stage reset, bit n drives stage n's `Reset_h`.
- `checkpoint` out 4: stage resumed on load/resurrect (1 or 2).
- `death_count` out 8: saturating count of deaths since reset.
- `Address` out 25: merged write address.

## Operation
- Reset: `stage`=0, `checkpoint`=1, `death_count`=0, `stage_rst`=6'b111111 for RST_FRAMES frames, settle counter loaded.
- On every stage entry: settle counter := RST_FRAMES, `stage_rst[new]`=1 while counter≠0; all event inputs for the active stage are masked while counter≠0.
- Transitions (only when counter==0):
  - 0 → `confirmed` & sel=1: stage 1, checkpoint:=1. sel=2: stage :=`checkpoint`. sel=3: stage 5.
  - 1 → death1: stage 3, death_count+1. Else reach_final: stage 2. `saved1`: checkpoint stays 1 (no transition).
  - 2 → death2: stage 3, death_count+1. Else victory: stage 4. `saved2`: checkpoint:=2 (no transition).
  - 3 → rising edge of `R`: stage :=`checkpoint`.
  - 4 → finish_game: stage 0.
  - 5 → terminal; leaves only on `Reset_h`.
- Priority in stages 1/2: death > reach_final/victory > save. Save and victory in the same frame: checkpoint updates and stage goes to 4.
- Death stage (3) is not reset on re-entry's counter alone: `stage_rst[3]` pulses only when entered from menu path never occurs; from 1/2 it pulses normally (clears score display latch).
- `death_count` saturates at 255.
- `Address` = bitwise OR of addr0..addr5 gated by `stage` (only addr[stage] passes); stage>5 → 0. Purely combinational.

## Timing
- Event sampled at edge k → `stage` new value after edge k; `stage_rst` asserted for edges k+1..k+RST_FRAMES; events honoured from edge k+RST_FRAMES+1.
- `R` edge: R_prev register; R high on reset leaves R_prev=1 so a held key does not resurrect.
- `Address` follows `stage` combinationally; zero-latency from addr inputs.
- `Reset_h` mid-transition overrides everything in the same edge.

## Structure
- Package `stage_pkg`: `stage_t` enum (MENU=0, LVL1, BOSS, DEATH, FINAL, EXIT), `NUM_STAGES`=6, `ADDR_W`=25.
- One sub-module `stage_addr_mux` (combinational select of six addresses by `stage`); FSM, counter, checkpoint, edge detect in the top.

## Test plan
- Reset, then confirmed with sel=1 → stage=1 one frame later, stage_rst=6'b000010 for 2 frames, death1 during those frames ignored.
- Stage 1, death1 & reach_final same frame → stage=3, death_count=1.
- Stage 2, saved2 then death2, then R pulse → stage 3, then stage 2, checkpoint=2; R held across reset produces no transition.
- Menu sel=2 after reset → stage=1 (checkpoint default 1).
- Stage 2 victory → 4; finish_game → 0; sel=3 → 5; further inputs ignored until Reset_h.
- addr1=25'h1ABCDE, others nonzero, stage=1 → Address=25'h1ABCDE; force 256 deaths → death_count=255.
